// File: rtl/memory_block_pkg.sv
// memory_block_pkg: default geometry and word type shared by the memory block
package memory_block_pkg;
  localparam int defDataW = 16;
  localparam int defAddrW = 16;
  localparam int defDepth = 256;
  typedef logic [defDataW-1:0] wordT;
endpackage

// File: rtl/mem_addr_check.sv
// mem_addr_check: flags whether a word address falls inside the implemented depth
module mem_addr_check #(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 256
) (
  input  logic [ADDR_W-1:0] address,
  output logic              inRange
);
  localparam logic [ADDR_W:0] limit = (ADDR_W+1)'(DEPTH);
  assign inRange = {1'b0, address} < limit;
endmodule

// File: rtl/memory_block.sv
// memory_block: word-addressed RAM with combinational read, clocked write and async clear
module memory_block
  import memory_block_pkg::*;
#(
  parameter int DATA_W = defDataW,
  parameter int ADDR_W = defAddrW,
  parameter int DEPTH = defDepth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wEn,
  output logic [DATA_W-1:0] outData,
  output logic              addr_err
);
  localparam int idxW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              inRange;
  logic [idxW-1:0]   idx;
  mem_addr_check #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) addrCheck (
    .address(address),
    .inRange(inRange)
  );
  assign idx = address[idxW-1:0];
  // Async clear of every word; otherwise store in-range writes on the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wEn && inRange) begin
      mem[idx] <= data;
    end
  end
  assign outData = inRange ? mem[idx] : '0;
  assign addr_err = !inRange;
endmodule

// File: tb/tb_memory_block.sv
// tb_memory_block: directed and randomized checks of memory_block against an array model
module tb_memory_block;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wEn = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] data = '0;
  logic [15:0] outData;
  logic        addr_err;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] model [256];

  memory_block dut (
    .clk(clk),
    .rst_n(rst_n),
    .address(address),
    .data(data),
    .wEn(wEn),
    .outData(outData),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] expRead(input logic [15:0] a);
    return (a < 16'd256) ? model[a[7:0]] : 16'h0000;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    checks++;
    assert (outData === exp) else begin
      errors++;
      $error("FAIL %s addr=%h outData=%h expected=%h", tag, address, outData, exp);
    end
    checks++;
    assert (addr_err === (address >= 16'd256)) else begin
      errors++;
      $error("FAIL %s_err addr=%h addr_err=%b expected=%b", tag, address, addr_err, address >= 16'd256);
    end
  endtask

  task automatic readAt(input string tag, input logic [15:0] a);
    wEn = 1'b0;
    address = a;
    #1;
    check(tag, expRead(a));
  endtask

  task automatic doWrite(input string tag, input logic [15:0] a, input logic [15:0] d, input logic en);
    @(negedge clk);
    address = a;
    data = d;
    wEn = en;
    #1;
    check({tag, "_pre"}, expRead(a));
    @(posedge clk);
    #1;
    if (en && a < 16'd256) model[a[7:0]] = d;
    check({tag, "_post"}, expRead(a));
  endtask

  initial begin
    clearModel();
    #3;
    readAt("rst_hold", 16'h0010);
    #8;
    rst_n = 1'b1;
    readAt("r0", 16'h0000);
    readAt("r1", 16'h0001);
    readAt("r255", 16'h00FF);
    doWrite("w0", 16'h0000, 16'h0F0F, 1'b1);
    doWrite("w0_idle", 16'h0000, 16'h0000, 1'b0);
    check("w0_val", 16'h0F0F);
    doWrite("w5", 16'h0005, 16'hAAAA, 1'b1);
    doWrite("w6", 16'h0006, 16'h5555, 1'b1);
    readAt("r5", 16'h0005);
    check("r5_val", 16'hAAAA);
    readAt("r6", 16'h0006);
    check("r6_val", 16'h5555);
    readAt("r5b", 16'h0005);
    doWrite("oob", 16'h0100, 16'h1234, 1'b1);
    check("oob_val", 16'h0000);
    readAt("r0_after_oob", 16'h0000);
    check("r0_keep", 16'h0F0F);
    doWrite("w3", 16'h0003, 16'hBEEF, 1'b1);
    @(negedge clk);
    address = 16'h0003;
    data = 16'h1234;
    wEn = 1'b1;
    #1;
    rst_n = 1'b0;
    clearModel();
    #1;
    check("rst_mid", 16'h0000);
    @(posedge clk);
    #1;
    check("rst_blocked", 16'h0000);
    wEn = 1'b0;
    #1;
    rst_n = 1'b1;
    readAt("r3_after_rst", 16'h0003);
    readAt("r5_after_rst", 16'h0005);
    doWrite("b2b1", 16'h0007, 16'h1111, 1'b1);
    doWrite("b2b2", 16'h0007, 16'h2222, 1'b1);
    check("b2b_val", 16'h2222);
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      case ($urandom_range(0, 7))
        0:       a = 16'($urandom);
        1, 2, 3: a = 16'($urandom_range(0, 15));
        default: a = 16'($urandom_range(0, 260));
      endcase
      doWrite("rnd", a, 16'($urandom), 1'($urandom_range(0, 2) != 0));
      if (n % 4 == 0) readAt("rnd_rd", 16'($urandom_range(0, 15)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_block.md
MEMORY_BLOCK -- requirements
Module: memory_block

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter SHALL be DATA_W, default 16, word width in bits.
REQ-003 Parameter SHALL be ADDR_W, default 16, address port width in bits.
REQ-004 Parameter SHALL be DEPTH, default 256, number of implemented words (DEPTH <= 2**ADDR_W).
REQ-005 Port SHALL be clk, input, 1, rising-edge clock for all writes.
REQ-006 Port SHALL be rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port SHALL be address, input, ADDR_W, word address shared by read and write.
REQ-008 Port SHALL be data, input, DATA_W, write data.
REQ-009 Port SHALL be wEn, input, 1, write enable, active high.
REQ-010 Port SHALL be outData, output, DATA_W, read data for the current address.
REQ-011 Port SHALL be addr_err, output, 1, high while address >= DEPTH.

Function
REQ-012 Storage SHALL be a word-addressed array of DEPTH words of DATA_W bits each; there SHALL be no byte lanes.
REQ-013 On each rising clk edge with rst_n=1, wEn=1 and address < DEPTH, data SHALL be written to mem[address].
REQ-014 A write SHALL take effect at that edge and be visible on outData immediately after it.
REQ-015 With wEn=0, memory contents SHALL be unchanged.
REQ-016 The read SHALL be combinational: outData = mem[address] whenever address < DEPTH.
REQ-017 outData SHALL update within the same cycle as address changes, with no clock needed.
REQ-018 While wEn=1 before the edge, outData SHALL show the old contents (read-before-write within the cycle); the new value SHALL appear after the edge.
REQ-019 For address >= DEPTH, a write SHALL be ignored, outData SHALL be all zeros, and addr_err SHALL be 1.
REQ-020 addr_err SHALL be combinational, with no clock needed.
REQ-021 Back-to-back writes to the same address on consecutive edges SHALL leave the last value written.
REQ-022 X/Z on wEn SHALL NOT be required to be handled; wEn is defined to be driven 0 or 1.

Reset
REQ-023 When rst_n=0, all DEPTH words SHALL clear to 0 asynchronously, with no clock edge required.
REQ-024 While rst_n=0, writes SHALL be blocked and outData SHALL read 0 for every address.
REQ-025 Deasserting rst_n SHALL NOT itself cause a write.
REQ-026 The first write after reset SHALL occur at the first rising edge with rst_n=1 and wEn=1.
REQ-027 Asserting rst_n in the middle of a cycle with wEn=1 SHALL discard that pending write.

Structure
REQ-028 A shared package SHALL hold the default DATA_W, ADDR_W and DEPTH constants and a word typedef (DATA_W-bit logic).
REQ-029 memory_block SHALL be a single module, one always block for reset/write and continuous assigns for outData and addr_err.
REQ-030 An optional sub-module, mem_addr_check, SHALL compute the in-range flag if reused elsewhere in the CPU.

Verification
REQ-031 Reset pulse, then read addresses 0, 1 and 255 -> outData=0x0000 each, addr_err=0.
REQ-032 address=0x0000, data=0x0F0F, wEn=1, one edge; then wEn=0, data=0x0000 -> outData=16'b0000111100001111 and mem[0] unchanged.
REQ-033 Write 0xAAAA to address 5 and 0x5555 to address 6, then read 5, 6, 5 combinationally with no clock -> 0xAAAA, 0x5555, 0xAAAA.
REQ-034 address=0x0100 (>= DEPTH), data=0x1234, wEn=1, edge -> addr_err=1, outData=0; a read of 0x0000 is unaffected.
REQ-035 Write 0xBEEF to address 3, assert rst_n=0 mid-cycle with no edge -> outData=0 at once; after release, address 3 reads 0x0000.
REQ-036 wEn=1 at address 7 with data 0x1111 then 0x2222 on consecutive edges -> outData shows the old value before each edge and 0x2222 finally.
